weight_loader: RTL

CPU-side writer for the MNIST accelerator's two weight memories, mapped as a PicoRV32 native-bus peripheral. Firmware streams layer-1 and layer-2 weights through a data register with auto-incrementing addresses. On launch the block writes the 32'h7fffffff stop sentinels at the configured stop indices and releases the accelerator's start/clear line. It then reports completion when both layers signal stop. It is the producer side of the sentinel-terminated weight stream that the accelerator control counters consume.

---
 rtl/weight_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// weight_loader: PicoRV32 native-bus peripheral that streams weights into the
// accelerator's two weight RAMs, seals both layers with stop sentinels, then
// releases the accelerator and reports completion once both layers stop.
module weight_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          L1_AW     = 10,
    parameter int          L2_AW     = 6,
    parameter int          L1_STOP   = 800,
    parameter int          L2_STOP   = 40,
    parameter logic [31:0] SENTINEL  = 32'h7fffffff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             w1_we,
    output logic [L1_AW-1:0] w1_addr,
    output logic [31:0]      w1_wdata,
    output logic             w2_we,
    output logic [L2_AW-1:0] w2_addr,
    output logic [31:0]      w2_wdata,
    output logic             accel_start,
    input  logic             stop1,
    input  logic             stop2
);

    // The pointer is shared by both layers, so it must cover the wider one.
    localparam int PW = (L1_AW > L2_AW) ? L1_AW : L2_AW;

    localparam logic [PW-1:0]    L1_LIMIT = PW'(L1_STOP);
    localparam logic [PW-1:0]    L2_LIMIT = PW'(L2_STOP);
    localparam logic [L1_AW-1:0] L1_SEAL0 = L1_AW'(L1_STOP);
    localparam logic [L1_AW-1:0] L1_SEAL1 = L1_AW'(L1_STOP + 1);
    localparam logic [L2_AW-1:0] L2_SEAL0 = L2_AW'(L2_STOP);
    localparam logic [L2_AW-1:0] L2_SEAL1 = L2_AW'(L2_STOP + 1);

    // Only word-aligned offsets are mapped; misaligned offsets behave as unmapped.
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_PTR    = 4'hC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD1 = 3'd1,
        LOAD2 = 3'd2,
        SEAL  = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic              overflow, overflow_n;
    logic              seal_phase, seal_phase_n;
    logic              ready_n;
    logic [31:0]       rdata_n;
    logic              w1_we_n, w2_we_n;
    logic [L1_AW-1:0]  w1_addr_n;
    logic [L2_AW-1:0]  w2_addr_n;
    logic [31:0]       w1_wdata_n, w2_wdata_n;
    logic              req;
    logic              is_write;

    // A request is new only when no acknowledge is currently being shown,
    // which also guarantees the idle cycle after every acknowledge.
    assign req      = mem_valid && !mem_ready && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_write = |mem_wstrb;

    // The accelerator counters are held cleared until the weights are sealed.
    assign accel_start = !(state == RUN || state == DONE);

    // Next-state, register decode and next values of all registered outputs.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        overflow_n   = overflow;
        seal_phase_n = seal_phase;
        ready_n      = 1'b0;
        rdata_n      = '0;
        w1_we_n      = 1'b0;
        w1_addr_n    = w1_addr;
        w1_wdata_n   = w1_wdata;
        w2_we_n      = 1'b0;
        w2_addr_n    = w2_addr;
        w2_wdata_n   = w2_wdata;

        case (state)
            SEAL: begin
                if (!seal_phase) begin
                    seal_phase_n = 1'b1;
                    w1_we_n      = 1'b1;
                    w1_addr_n    = L1_SEAL1;
                    w1_wdata_n   = SENTINEL;
                    w2_we_n      = 1'b1;
                    w2_addr_n    = L2_SEAL1;
                    w2_wdata_n   = SENTINEL;
                end else begin
                    seal_phase_n = 1'b0;
                    state_n      = RUN;
                end
            end
            RUN: begin
                if (stop1 && stop2) begin
                    state_n = DONE;
                end
            end
            default: ;
        endcase

        if (req) begin
            ready_n = 1'b1;
            if (is_write) begin
                case (mem_addr[3:0])
                    OFF_CTRL: begin
                        if (mem_wdata[2]) begin
                            if (state == IDLE || state == LOAD1 || state == LOAD2) begin
                                state_n      = SEAL;
                                seal_phase_n = 1'b0;
                                w1_we_n      = 1'b1;
                                w1_addr_n    = L1_SEAL0;
                                w1_wdata_n   = SENTINEL;
                                w2_we_n      = 1'b1;
                                w2_addr_n    = L2_SEAL0;
                                w2_wdata_n   = SENTINEL;
                            end
                        end else if (state != SEAL && (mem_wdata[1] || mem_wdata[0])) begin
                            state_n    = mem_wdata[1] ? LOAD2 : LOAD1;
                            ptr_n      = '0;
                            overflow_n = 1'b0;
                        end
                    end
                    OFF_DATA: begin
                        if (state == LOAD1) begin
                            if (ptr < L1_LIMIT) begin
                                w1_we_n    = 1'b1;
                                w1_addr_n  = L1_AW'(ptr);
                                w1_wdata_n = mem_wdata;
                                ptr_n      = ptr + PW'(1);
                            end else begin
                                overflow_n = 1'b1;
                            end
                        end else if (state == LOAD2) begin
                            if (ptr < L2_LIMIT) begin
                                w2_we_n    = 1'b1;
                                w2_addr_n  = L2_AW'(ptr);
                                w2_wdata_n = mem_wdata;
                                ptr_n      = ptr + PW'(1);
                            end else begin
                                overflow_n = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (mem_addr[3:0])
                    OFF_STATUS: rdata_n = {27'b0, overflow, (state == DONE), state};
                    OFF_PTR:    rdata_n = 32'(ptr);
                    default:    rdata_n = '0;
                endcase
            end
        end
    end

    // State, pointer, flags and all bus/weight-port outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            overflow   <= 1'b0;
            seal_phase <= 1'b0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            w1_we      <= 1'b0;
            w1_addr    <= '0;
            w1_wdata   <= '0;
            w2_we      <= 1'b0;
            w2_addr    <= '0;
            w2_wdata   <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            overflow   <= overflow_n;
            seal_phase <= seal_phase_n;
            mem_ready  <= ready_n;
            mem_rdata  <= rdata_n;
            w1_we      <= w1_we_n;
            w1_addr    <= w1_addr_n;
            w1_wdata   <= w1_wdata_n;
            w2_we      <= w2_we_n;
            w2_addr    <= w2_addr_n;
            w2_wdata   <= w2_wdata_n;
        end
    end

endmodule
